// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : Opcodes, ALUOp encodings and per-stage control bundles
// Revision: 1.0
// ============================================================================
package pipe_pkg;

    localparam int unsigned c_op_rtype = 0;
    localparam int unsigned c_op_addi  = 1;
    localparam int unsigned c_op_lw    = 2;
    localparam int unsigned c_op_sw    = 3;
    localparam int unsigned c_op_beq   = 4;
    localparam int unsigned c_op_jump  = 5;

    localparam logic [1:0] c_aluop_funct = 2'b00;
    localparam logic [1:0] c_aluop_add   = 2'b01;
    localparam logic [1:0] c_aluop_sub   = 2'b10;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       extop;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       extop;
        logic [1:0] aluop;
        logic       memwrite;
        logic       branch;
        logic       regwrite;
        logic       memtoreg;
    } ex_ctrl_t;

    typedef struct packed {
        logic memwrite;
        logic branch;
        logic regwrite;
        logic memtoreg;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_decode
// Brief   : Combinational ID-stage opcode decoder; unknown/invalid -> bubble
// Revision: 1.0
// ============================================================================
module ctrl_decode
    import pipe_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            i_valid,
    input  logic [OP_W-1:0] i_op,
    output ctrl_t           o_ctrl,
    output logic            o_known
);

    always_comb begin
        o_ctrl  = '0;
        o_known = 1'b0;
        if (i_valid) begin
            o_known = 1'b1;
            case (i_op)
                OP_W'(c_op_rtype): begin
                    o_ctrl.regdst   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.aluop    = c_aluop_funct;
                end
                OP_W'(c_op_addi): begin
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.aluop    = c_aluop_add;
                end
                OP_W'(c_op_lw): begin
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.memtoreg = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.extop    = 1'b1;
                    o_ctrl.aluop    = c_aluop_add;
                end
                OP_W'(c_op_sw): begin
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.memwrite = 1'b1;
                    o_ctrl.extop    = 1'b1;
                    o_ctrl.aluop    = c_aluop_add;
                end
                OP_W'(c_op_beq): begin
                    o_ctrl.branch   = 1'b1;
                    o_ctrl.aluop    = c_aluop_sub;
                end
                OP_W'(c_op_jump): begin
                    o_ctrl.jump     = 1'b1;
                end
                default: begin
                    o_known = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl
// Brief   : ID decode, load-use hazard detection and EX/MEM/WB control pipe
// Revision: 1.0
// ============================================================================
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int REG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_op,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               flush,
    output logic               id_jump,
    output logic               id_stall,
    output logic               id_illegal,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic               ex_extop,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               mem_memwrite,
    output logic               mem_branch,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_dst
);

    ctrl_t            w_dec;
    logic             w_known;
    logic [REG_W-1:0] w_id_dst;
    logic             w_load_use;
    logic             w_pass;
    ex_ctrl_t         w_ex_next;
    logic [REG_W-1:0] w_ex_dst_next;

    ex_ctrl_t         r_ex;
    logic [REG_W-1:0] r_ex_dst;
    mem_ctrl_t        r_mem;
    logic [REG_W-1:0] r_mem_dst;
    wb_ctrl_t         r_wb;
    logic [REG_W-1:0] r_wb_dst;

    ctrl_decode #(
        .OP_W (OP_W)
    ) u_ctrl_decode (
        .i_valid (id_valid),
        .i_op    (id_op),
        .o_ctrl  (w_dec),
        .o_known (w_known)
    );

    assign id_jump    = w_dec.jump;
    assign id_illegal = id_valid & ~flush & ~w_known;
    assign w_id_dst   = w_dec.regdst ? id_rd : id_rt;

    // Only lw carries memtoreg, so it identifies a load sitting in EX.
    assign w_load_use = r_ex.memtoreg & r_ex.regwrite & (r_ex_dst != '0) &
                        ((r_ex_dst == id_rs) |
                         ((r_ex_dst == id_rt) & (w_dec.regdst | w_dec.branch)));
    assign id_stall   = rst_n & ~flush & id_valid & w_load_use;

    // Jumps redirect through id_jump only; nothing of them travels down the pipe.
    assign w_pass = w_known & ~w_dec.jump & ~id_stall & ~flush;

    always_comb begin
        w_ex_next     = '0;
        w_ex_dst_next = '0;
        if (w_pass) begin
            w_ex_next.regdst   = w_dec.regdst;
            w_ex_next.alusrc   = w_dec.alusrc;
            w_ex_next.extop    = w_dec.extop;
            w_ex_next.aluop    = w_dec.aluop;
            w_ex_next.memwrite = w_dec.memwrite;
            w_ex_next.branch   = w_dec.branch;
            w_ex_next.regwrite = w_dec.regwrite & (w_id_dst != '0);
            w_ex_next.memtoreg = w_dec.memtoreg;
            w_ex_dst_next      = w_id_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex      <= '0;
            r_ex_dst  <= '0;
            r_mem     <= '0;
            r_mem_dst <= '0;
            r_wb      <= '0;
            r_wb_dst  <= '0;
        end else begin
            r_ex           <= w_ex_next;
            r_ex_dst       <= w_ex_dst_next;
            r_mem.memwrite <= r_ex.memwrite;
            r_mem.branch   <= r_ex.branch;
            r_mem.regwrite <= r_ex.regwrite;
            r_mem.memtoreg <= r_ex.memtoreg;
            r_mem_dst      <= r_ex_dst;
            r_wb.regwrite  <= r_mem.regwrite;
            r_wb.memtoreg  <= r_mem.memtoreg;
            r_wb_dst       <= r_mem_dst;
        end
    end

    assign ex_regdst    = r_ex.regdst;
    assign ex_alusrc    = r_ex.alusrc;
    assign ex_extop     = r_ex.extop;
    assign ex_aluop     = ALUOP_W'(r_ex.aluop);
    assign mem_memwrite = r_mem.memwrite;
    assign mem_branch   = r_mem.branch;
    assign wb_regwrite  = r_wb.regwrite;
    assign wb_memtoreg  = r_wb.memtoreg;
    assign wb_dst       = r_wb_dst;

endmodule
`default_nettype wire
